// File: rtl/fft_seq_pkg.sv
// Shared types and constants for the FFT frame sequencer.
//  seq_state : frame FSM states
//  owner     : which side currently drives the sample-RAM port
//  RE_*/IM_* : bit positions of the real/imag halves inside a RAM word
package fft_seq_pkg;

  typedef enum logic [2:0] {
    SEQ_LOAD,
    SEQ_CHECK,
    SEQ_START,
    SEQ_RUN,
    SEQ_NEXT,
    SEQ_DONE,
    SEQ_ERR
  } seq_state;

  typedef enum logic {
    OWN_BRIDGE,
    OWN_CORE
  } owner;

  localparam int unsigned RE_MSB   = 31;
  localparam int unsigned RE_LSB   = 16;
  localparam int unsigned IM_MSB   = 15;
  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned LOG2N_W  = 4;

  // The butterfly core holds the RAM from its start pulse until the stage decision.
  function automatic owner owner_of(input seq_state s);
    return (s == SEQ_START || s == SEQ_RUN || s == SEQ_NEXT) ? OWN_CORE : OWN_BRIDGE;
  endfunction

endpackage

// File: rtl/fft_pow2_check.sv
// Frame-length qualifier (purely combinational).
//  i_n     : requested frame length N
//  o_legal : N is a power of two with 2 <= N <= 2**MAX_LOG2N
//  o_log2n : log2(N) when legal, 0 otherwise
module fft_pow2_check
  import fft_seq_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned MAX_LOG2N  = 10
) (
  input  logic [ADDR_WIDTH-1:0] i_n,
  output logic                  o_legal,
  output logic [LOG2N_W-1:0]    o_log2n
);

  // Bit 0 is excluded on purpose: N=1 is not a usable frame.
  always_comb begin
    o_legal = 1'b0;
    o_log2n = '0;
    for (int unsigned i = 1; i < ADDR_WIDTH; i++) begin
      if (i <= MAX_LOG2N && i_n == (ADDR_WIDTH'(1) << i)) begin
        o_legal = 1'b1;
        o_log2n = LOG2N_W'(i);
      end
    end
  end

endmodule

// File: rtl/fft_frame_sequencer.sv
// FFT frame sequencer: load -> log2(N) butterfly stages -> unload.
// Owns the single sample-RAM port and muxes it between the AXI bridge and the butterfly core.
// Optional build macro: FFT_SEQ_WDOG_EN adds a per-stage watchdog of WDOG_CYCLES RUN cycles.
// Ports:
//  i_clk, i_rstn                 clock / asynchronous active-low reset
//  i_DATA_LOADED, i_SAMPLES_NUMBER  bridge: frame loaded, frame length N
//  i_UNLOAD_DONE                 results consumed, frame released
//  i_br_*                        bridge RAM requests
//  o_core_start/stage/log2n      core stage control
//  i_core_done, i_core_*         core stage completion and RAM requests
//  o_ram_*                       sample RAM port
//  o_CALC_END, o_busy, o_err     frame status
//  o_br_blocked                  bridge access dropped while the core owns the RAM
module fft_frame_sequencer
  import fft_seq_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MAX_LOG2N   = 10,
  parameter int unsigned WDOG_CYCLES = 4096
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_DATA_LOADED,
  input  logic [ADDR_WIDTH-1:0] i_SAMPLES_NUMBER,
  input  logic                  i_UNLOAD_DONE,
  input  logic                  i_br_write,
  input  logic                  i_br_read,
  input  logic [ADDR_WIDTH-1:0] i_br_index,
  input  logic [SAMPLE_W-1:0]   i_br_sample,
  output logic                  o_core_start,
  output logic [LOG2N_W-1:0]    o_core_stage,
  output logic [LOG2N_W-1:0]    o_core_log2n,
  input  logic                  i_core_done,
  input  logic                  i_core_we,
  input  logic                  i_core_re,
  input  logic [ADDR_WIDTH-1:0] i_core_addr,
  input  logic [DATA_WIDTH-1:0] i_core_wdata,
  output logic                  o_ram_we,
  output logic                  o_ram_re,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_wdata,
  output logic                  o_CALC_END,
  output logic                  o_busy,
  output logic                  o_err,
  output logic                  o_br_blocked
);

  seq_state             state_q;
  logic [LOG2N_W-1:0]   stage_q, log2n_q;
  logic                 start_q, calc_end_q, busy_q, err_q;
  // Cleared once a frame is accepted; re-armed only after DATA_LOADED is seen low.
  logic                 armed_q;
  logic                 n_legal;
  logic [LOG2N_W-1:0]   n_log2n;
  owner                 ram_owner;

`ifdef FFT_SEQ_WDOG_EN
  logic [31:0]          wdog_q;
`endif

  fft_pow2_check #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .MAX_LOG2N  (MAX_LOG2N)
  ) u_pow2_check (
    .i_n     (i_SAMPLES_NUMBER),
    .o_legal (n_legal),
    .o_log2n (n_log2n)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= SEQ_LOAD;
      stage_q    <= '0;
      log2n_q    <= '0;
      start_q    <= 1'b0;
      calc_end_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      armed_q    <= 1'b1;
`ifdef FFT_SEQ_WDOG_EN
      wdog_q     <= '0;
`endif
    end else begin
      start_q <= 1'b0;
      if (!i_DATA_LOADED) armed_q <= 1'b1;
      case (state_q)
        SEQ_LOAD: begin
          if (i_DATA_LOADED && armed_q) begin
            armed_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= SEQ_CHECK;
          end
        end
        SEQ_CHECK: begin
          if (n_legal) begin
            log2n_q <= n_log2n;
            stage_q <= '0;
            start_q <= 1'b1;
            state_q <= SEQ_START;
          end else begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= SEQ_ERR;
          end
        end
        SEQ_START: begin
`ifdef FFT_SEQ_WDOG_EN
          wdog_q  <= '0;
`endif
          state_q <= SEQ_RUN;
        end
        SEQ_RUN: begin
          if (i_core_done) begin
            state_q <= SEQ_NEXT;
          end
`ifdef FFT_SEQ_WDOG_EN
          else if (wdog_q == WDOG_CYCLES - 1) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= SEQ_ERR;
          end else begin
            wdog_q  <= wdog_q + 32'd1;
          end
`endif
        end
        SEQ_NEXT: begin
          if (stage_q == log2n_q - LOG2N_W'(1)) begin
            calc_end_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= SEQ_DONE;
          end else begin
            stage_q <= stage_q + LOG2N_W'(1);
            start_q <= 1'b1;
            state_q <= SEQ_START;
          end
        end
        SEQ_DONE, SEQ_ERR: begin
          if (i_UNLOAD_DONE) begin
            calc_end_q <= 1'b0;
            err_q      <= 1'b0;
            state_q    <= SEQ_LOAD;
          end
        end
        default: state_q <= SEQ_LOAD;
      endcase
    end
  end

  assign ram_owner = owner_of(state_q);

  // Gated by i_rstn so the RAM enables drop the moment reset asserts.
  always_comb begin
    o_ram_we     = 1'b0;
    o_ram_re     = 1'b0;
    o_ram_addr   = '0;
    o_ram_wdata  = '0;
    o_br_blocked = 1'b0;
    if (i_rstn) begin
      unique case (ram_owner)
        OWN_CORE: begin
          o_ram_we     = i_core_we;
          o_ram_re     = i_core_re;
          o_ram_addr   = i_core_addr;
          o_ram_wdata  = i_core_wdata;
          o_br_blocked = i_br_write | i_br_read;
        end
        OWN_BRIDGE: begin
          o_ram_we   = i_br_write;
          o_ram_re   = i_br_read & ~i_br_write;  // write wins a collision
          o_ram_addr = i_br_index;
          o_ram_wdata[RE_MSB:RE_LSB] = i_br_sample;
        end
        default: ;
      endcase
    end
  end

  assign o_core_start = start_q;
  assign o_core_stage = stage_q;
  assign o_core_log2n = log2n_q;
  assign o_CALC_END   = calc_end_q;
  assign o_busy       = busy_q;
  assign o_err        = err_q;

endmodule
